// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encodings,
// control-field bit positions, and the packed bundle of register enables.
package pipe_hazard_ctrl_pkg;

    localparam int INTERNAL_BITS = 32;
    localparam int REG_ADDR_W    = 5;

    // Bit positions inside the pipeline M / WB control fields
    localparam int MEM_WRITE_BIT  = 0;
    localparam int MEM_READ_BIT   = 1;
    localparam int BRANCH_BIT     = 2;
    localparam int MEM_TO_REG_BIT = 0;
    localparam int REG_WRITE_BIT  = 1;

    typedef enum logic [1:0] {
        HZ_RUN       = 2'd0,
        HZ_DMEM_WAIT = 2'd1,
        HZ_IMEM_WAIT = 2'd2,
        HZ_REDIRECT  = 2'd3
    } hz_state_e;

    // Action chosen for the current cycle; each maps to one enable/flush pattern
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_REDIRECT,
        ACT_FREEZE,
        ACT_LOAD_USE,
        ACT_IFETCH
    } hz_act_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic ex_mem_flush;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    // Held while reset is asserted: nothing loads, everything is bubbled
    localparam hz_ctrl_t HZ_CTRL_RESET = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
        id_ex_write: 1'b0, id_ex_flush: 1'b1, ex_mem_write: 1'b0,
        ex_mem_flush: 1'b1, mem_wb_bubble: 1'b1};

    function automatic hz_ctrl_t hz_ctrl(hz_act_e act);
        hz_ctrl_t c;
        c = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
              id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
              ex_mem_flush: 1'b0, mem_wb_bubble: 1'b0};
        case (act)
            ACT_REDIRECT: begin
                // PC loads the branch target; all younger instructions die
                c.if_id_flush  = 1'b1;
                c.id_ex_flush  = 1'b1;
                c.ex_mem_flush = 1'b1;
            end
            ACT_FREEZE: begin
                c.pc_write      = 1'b0;
                c.if_id_write   = 1'b0;
                c.id_ex_write   = 1'b0;
                c.ex_mem_write  = 1'b0;
                c.mem_wb_bubble = 1'b1;
            end
            ACT_LOAD_USE: begin
                c.pc_write    = 1'b0;
                c.if_id_write = 1'b0;
                c.id_ex_flush = 1'b1;
            end
            ACT_IFETCH: begin
                c.pc_write    = 1'b0;
                c.if_id_flush = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    output logic                  load_use
);

    // $zero is never a real dependency
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe plus saturating perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int INTERNAL_BITS = 32,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  imem_ready,
    input  logic                  cnt_clr,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_bubble,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [1:0]            state
);

    if (INTERNAL_BITS != pipe_hazard_ctrl_pkg::INTERNAL_BITS) begin : g_width_chk
        $error("INTERNAL_BITS disagrees with the shared datapath width");
    end

    hz_state_e state_q, state_nxt;
    hz_act_e   act;
    hz_ctrl_t  ctrl;
    logic      load_use;
    logic      dstall;

    load_use_detect u_lud (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    assign dstall = dmem_req && !dmem_ready;

    // State register; reset drops any pending wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HZ_RUN;
        else        state_q <= state_nxt;
    end

    // Next state and cycle action, by per-state priority
    always_comb begin
        act       = ACT_NONE;
        state_nxt = HZ_RUN;
        unique case (state_q)
            HZ_RUN, HZ_DMEM_WAIT: begin
                if (state_q == HZ_DMEM_WAIT && !dmem_ready) begin
                    act = ACT_FREEZE; state_nxt = HZ_DMEM_WAIT;
                end else if (mem_branch_taken) begin
                    act = ACT_REDIRECT; state_nxt = HZ_REDIRECT;
                end else if (state_q == HZ_RUN && dstall) begin
                    act = ACT_FREEZE; state_nxt = HZ_DMEM_WAIT;
                end else if (load_use) begin
                    act = ACT_LOAD_USE;
                end else if (!imem_ready) begin
                    act = ACT_IFETCH; state_nxt = HZ_IMEM_WAIT;
                end
            end
            HZ_IMEM_WAIT: begin
                if (mem_branch_taken) begin
                    act = ACT_REDIRECT; state_nxt = HZ_REDIRECT;
                end else if (dstall) begin
                    act = ACT_FREEZE; state_nxt = HZ_DMEM_WAIT;
                end else if (!imem_ready) begin
                    act = ACT_IFETCH; state_nxt = HZ_IMEM_WAIT;
                end else if (load_use) begin
                    act = ACT_LOAD_USE;
                end
            end
            HZ_REDIRECT: begin
                // ID holds the flushed bubble, so load_use is ignored here
                if (!imem_ready) begin
                    act = ACT_IFETCH; state_nxt = HZ_IMEM_WAIT;
                end
            end
            default: ;
        endcase
    end

    // Output decode; reset forces the all-bubble pattern asynchronously
    always_comb begin
        ctrl = rst_n ? hz_ctrl(act) : HZ_CTRL_RESET;
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_write   = ctrl.id_ex_write;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign ex_mem_flush  = ctrl.ex_mem_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign state         = state_q;

    // Saturating stall counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                stall_cnt <= '0;
        else if (cnt_clr)                          stall_cnt <= '0;
        else if (!ctrl.pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end

    // Saturating redirect counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          flush_cnt <= '0;
        else if (cnt_clr)                                    flush_cnt <= '0;
        else if (act == ACT_REDIRECT && flush_cnt != '1)     flush_cnt <= flush_cnt + 1'b1;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, redirects on a taken branch resolved in MEM, and freezes or bubbles the pipe on instruction- and data-memory wait states.
- Drives the write-enable and flush inputs of every pipeline register and of the PC.
- Keeps saturating stall and flush counters for performance monitoring.

Parameters:
- INTERNAL_BITS, 32 (from def.v): datapath width; used only for consistency checks.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt (R-type, store, branch).
- ex_mem_read  in  1  mem-read bit of the ID/EX M-field.
- ex_rt  in  5  Instruction_20_16 held in ID/EX (load destination).
- mem_branch_taken  in  1  branch & ALU zero in the MEM stage.
- dmem_req  in  1  MEM stage performs a load or store.
- dmem_ready  in  1  data memory completes this cycle.
- imem_ready  in  1  instruction fetch completes this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear (bubble).
- id_ex_write  out  1  ID/EX load enable.
- id_ex_flush  out  1  zero the ID/EX WB/M/EX control fields.
- ex_mem_write  out  1  EX/MEM load enable.
- ex_mem_flush  out  1  zero the EX/MEM control fields.
- mem_wb_bubble  out  1  MEM/WB captures zero controls.
- stall_cnt  out  CNT_W  cycles with pc_write=0.
- flush_cnt  out  CNT_W  taken-branch redirects.
- state  out  2  current FSM state (debug).

Behaviour:
- State encoding: RUN=0, DMEM_WAIT=1, IMEM_WAIT=2, REDIRECT=3. State and counters are flops; control outputs are combinational from state and inputs.
- Reset (rst_n=0, asynchronous):
  - state=RUN; stall_cnt=0; flush_cnt=0.
  - While rst_n=0: all *_write=0, all *_flush=1, mem_wb_bubble=1.
- Default outputs: all *_write=1, all flushes=0, mem_wb_bubble=0.
- load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- RUN rules, highest priority first:
  1. mem_branch_taken: pc_write=1 (target selected externally); if_id_flush, id_ex_flush and ex_mem_flush all =1; flush_cnt+1; next REDIRECT. dmem_req is ignored in this cycle (a branch never accesses memory).
  2. dmem_req & !dmem_ready: pc_write, if_id_write, id_ex_write and ex_mem_write all =0; mem_wb_bubble=1; next DMEM_WAIT.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1; stay RUN. Exactly one bubble results, because the flushed ID/EX no longer has mem_read set.
  4. !imem_ready: pc_write=0, if_id_flush=1 (bubble enters ID; downstream advances); next IMEM_WAIT.
- DMEM_WAIT:
  - While !dmem_ready: full freeze exactly as RUN rule 2.
  - When dmem_ready=1: apply the RUN rules this same cycle, excluding rule 2 (rules 1, 3, 4 in order); next state per that evaluation, else RUN.
- IMEM_WAIT:
  - mem_branch_taken preempts: behave as rule 1.
  - dmem_req & !dmem_ready: behave as rule 2 and go to DMEM_WAIT.
  - Otherwise, while !imem_ready: pc_write=0, if_id_flush=1.
  - When imem_ready=1: apply RUN rules 3, 4; next RUN.
- REDIRECT:
  - One cycle in which the target fetch is issued; load_use is masked (ID holds the flushed bubble).
  - !imem_ready → IMEM_WAIT with IMEM_WAIT outputs; otherwise default outputs and next RUN.
- Counters:
  - stall_cnt increments on every cycle with pc_write=0 and rst_n=1.
  - Both counters saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment: the counter reads 0 on the next cycle.
- Simultaneous events: resolved strictly by the priority above. A taken branch always wins, because every younger instruction is discarded.
- Reset mid-stall: FSM returns to RUN immediately; no pending wait is remembered.

Decomposition:
- def.v (shared): state encodings (`HZ_RUN`, `HZ_DMEM_WAIT`, `HZ_IMEM_WAIT`, `HZ_REDIRECT`) and bit indices of the M/WB/EX control fields (MEM_READ_BIT=1, etc.) so that decoders stay consistent.
- One sub-module, load_use_detect: purely combinational comparator producing load_use. The FSM and counters stay in pipe_hazard_ctrl.

Test Plan:
- lw $5 in EX (ex_mem_read=1, ex_rt=5), id_rs=5 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0→1; next cycle all writes=1.
- ex_rt=0 with ex_mem_read=1, id_rs=0 → no stall; also id_rt match with id_uses_rt=0 → no stall.
- dmem_req=1, dmem_ready low for 3 cycles → full freeze for 3 cycles; state=DMEM_WAIT; stall_cnt=3; release on the 4th cycle with state=RUN.
- mem_branch_taken=1 coincident with load_use and !imem_ready → three flushes=1, pc_write=1, flush_cnt=1; REDIRECT, then RUN.
- Counter saturation with CNT_W=4 and 20 stall cycles → stall_cnt=15; pulse cnt_clr → 0.
- rst_n dropped mid-DMEM_WAIT → outputs immediately forced to reset values; after release, state=RUN and counters=0.
